rv32i_decode_stage: RTL

- Instruction-decode pipeline stage that produces the ALU's 4-bit operation select, its operand-source selects and the immediate for the RV32I datapath.
- Sits between fetch and execute.
- Combinational decode feeds a valid/ready register slice with a skid entry: full throughput, registered in_ready, synchronous flush.

---
 rtl/rv32i_pkg.sv | 81 ++++++++
 rtl/rv32i_dec_comb.sv | 149 ++++++++++++++
 rtl/rv32i_decode_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I decode stage: ALU op codes, operand selects,
// opcode constants and the decoded payload bundle.
package rv32i_pkg;

    localparam int XLEN_C = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SLT    = 4'b0111,
        ALU_SLTU   = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_A = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_PC4  = 2'b10,
        A_ZERO = 2'b11
    } a_sel_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_e;

    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6f;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0f;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        alu_op_e           alu_sel;
        a_sel_e            a_sel;
        b_sel_e            b_sel;
        logic [XLEN_C-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              reg_we;
        logic              mem_re;
        logic              mem_we;
        logic              branch;
        logic              jump;
        logic              illegal;
    } dec_bundle_t;

    // Base-ALU op for the funct3 encodings shared by OP and OP-IMM
    // (funct7 = 0 variants).
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_dec_comb.sv
// Purely combinational RV32I instruction decoder: instruction word in,
// ALU/operand selects, immediate and control flags out.
import rv32i_pkg::*;

module rv32i_dec_comb (
    input  logic [31:0]  instr,
    output dec_bundle_t  dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    // Decode by opcode, then squash everything but the register fields
    // when the encoding is not a legal RV32I instruction.
    always_comb begin
        logic ill;
        ill = 1'b0;

        dec         = '0;
        dec.alu_sel = ALU_ADD;
        dec.a_sel   = A_RS1;
        dec.b_sel   = B_RS2;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.funct3  = funct3;

        case (opcode)
            OPC_OP: begin
                dec.reg_we = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec.alu_sel = alu_from_funct3(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.alu_sel = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.alu_sel = ALU_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.reg_we = 1'b1;
                dec.b_sel  = B_IMM;
                if (funct3 == 3'b001) begin
                    dec.alu_sel = ALU_SLL;
                    dec.imm     = imm_sh;
                    ill         = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec.alu_sel = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec.imm     = imm_sh;
                    ill         = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    dec.alu_sel = alu_from_funct3(funct3);
                    dec.imm     = imm_i;
                end
            end
            OPC_LUI: begin
                dec.reg_we = 1'b1;
                dec.a_sel  = A_ZERO;
                dec.b_sel  = B_IMM;
                dec.imm    = imm_u;
            end
            OPC_AUIPC: begin
                dec.reg_we = 1'b1;
                dec.a_sel  = A_PC;
                dec.b_sel  = B_IMM;
                dec.imm    = imm_u;
            end
            OPC_JAL: begin
                dec.reg_we  = 1'b1;
                dec.jump    = 1'b1;
                dec.a_sel   = A_PC4;
                dec.b_sel   = B_IMM;
                dec.alu_sel = ALU_PASS_A;
                dec.imm     = imm_j;
            end
            OPC_JALR: begin
                dec.reg_we  = 1'b1;
                dec.jump    = 1'b1;
                dec.a_sel   = A_PC4;
                dec.b_sel   = B_IMM;
                dec.alu_sel = ALU_PASS_A;
                dec.imm     = imm_i;
                ill         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.alu_sel = ALU_SUB;
                    3'b100, 3'b101: dec.alu_sel = ALU_SLT;
                    3'b110, 3'b111: dec.alu_sel = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.reg_we = 1'b1;
                dec.mem_re = 1'b1;
                dec.b_sel  = B_IMM;
                dec.imm    = imm_i;
                ill        = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.mem_we = 1'b1;
                dec.b_sel  = B_IMM;
                dec.imm    = imm_s;
                ill        = (funct3 > 3'b010);
            end
            OPC_MISC_MEM: begin
                // FENCE is a no-op for this in-order core.
            end
            default: begin
                ill = 1'b1;
            end
        endcase

        if (ill) begin
            dec.alu_sel = ALU_ADD;
            dec.a_sel   = A_RS1;
            dec.b_sel   = B_RS2;
            dec.imm     = '0;
            dec.reg_we  = 1'b0;
            dec.mem_re  = 1'b0;
            dec.mem_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jump    = 1'b0;
        end
        dec.illegal = ill;
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: combinational decode feeding a valid/ready
// register slice with one skid entry. in_ready is registered and simply
// reflects an empty skid, so fetch never sees a combinational path from
// out_ready.
import rv32i_pkg::*;

module rv32i_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_alu_sel,
    output logic [1:0]      out_a_sel,
    output logic            out_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    dec_bundle_t     dec_d;
    dec_bundle_t     out_q;
    dec_bundle_t     skid_q;
    logic [PC_W-1:0] out_pc_q;
    logic [PC_W-1:0] skid_pc_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic            in_ready_q;

    logic            accept;
    logic            load_out;
    logic            out_valid_d;
    logic            skid_valid_d;

    rv32i_dec_comb u_dec (
        .instr (in_instr),
        .dec   (dec_d)
    );

    // Next occupancy of the output register and the skid entry.
    always_comb begin
        accept       = in_valid & in_ready_q;
        load_out     = ~out_valid_q | out_ready;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = accept;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
        end
    end

    // Valid bits and the registered ready; reset wins over flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    // Payload: output register refills from the skid first so order is
    // preserved; an accept while the output is stalled lands in the skid.
    // in_ready is low whenever the skid is full, so accept and a full skid
    // never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_pc_q  <= '0;
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else if (!flush) begin
            if (load_out && skid_valid_q) begin
                out_q    <= skid_q;
                out_pc_q <= skid_pc_q;
            end else if (load_out && accept) begin
                out_q    <= dec_d;
                out_pc_q <= in_pc;
            end
            if (!load_out && accept) begin
                skid_q    <= dec_d;
                skid_pc_q <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_alu_sel = out_q.alu_sel;
    assign out_a_sel   = out_q.a_sel;
    assign out_b_sel   = out_q.b_sel;
    assign out_imm     = out_q.imm;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_funct3  = out_q.funct3;
    assign out_reg_we  = out_q.reg_we;
    assign out_mem_re  = out_q.mem_re;
    assign out_mem_we  = out_q.mem_we;
    assign out_branch  = out_q.branch;
    assign out_jump    = out_q.jump;
    assign out_illegal = out_q.illegal;

endmodule
